// File: rtl/myproject_mac_pipe.sv
// myproject_mac_pipe: pipelined signed multiply-accumulate with framed accumulation and valid/ready result register
// Ports: ap_clk/ap_rst_n clock and async active-low reset; ce global enable;
//   in_valid/in_ready/din0/din1/first/last operand beat stream;
//   out_valid/out_ready/dout/ovf accumulated result with sticky overflow flag.
module myproject_mac_pipe #(
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 6,
  parameter int acc_WIDTH  = 32,
  parameter int NUM_STAGE  = 2,
  parameter int SATURATE   = 0
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ce,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  input  logic                         first,
  input  logic                         last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [acc_WIDTH-1:0]  dout,
  output logic                         ovf
);
  localparam int PW = din0_WIDTH + din1_WIDTH;
  localparam int L  = NUM_STAGE - 1;
  localparam int M  = acc_WIDTH - 1;
  localparam logic [acc_WIDTH-1:0] MAXV = {1'b0, {M{1'b1}}};
  logic                        w_adv;
  logic signed [PW-1:0]        w_prod;
  logic signed [acc_WIDTH-1:0] w_pext;
  logic signed [acc_WIDTH-1:0] r_p [NUM_STAGE];
  logic [NUM_STAGE-1:0]        r_v, r_f, r_l;
  logic signed [acc_WIDTH-1:0] r_acc, w_base, w_sum, w_acc_n;
  logic                        r_ovf_acc, w_ov, w_ovf_n;
  logic                        r_out_valid, r_ovf;
  logic signed [acc_WIDTH-1:0] r_dout;
  assign w_adv     = ce & (~r_out_valid | out_ready);
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign ovf       = r_ovf;
  assign w_prod    = PW'(din0) * PW'(din1);
  assign w_pext    = acc_WIDTH'(w_prod);
  // A first beat starts from zero, so its add can never overflow and the sticky flag restarts.
  always_comb begin
    w_base  = r_f[L] ? '0 : r_acc;
    w_sum   = w_base + r_p[L];
    w_ov    = (w_base[M] == r_p[L][M]) & (w_sum[M] != r_p[L][M]);
    w_acc_n = (SATURATE != 0 && w_ov) ? (r_p[L][M] ? ~MAXV : MAXV) : w_sum;
    w_ovf_n = (~r_f[L] & r_ovf_acc) | w_ov;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_STAGE; i++) r_p[i] <= '0;
      r_v         <= '0;
      r_f         <= '0;
      r_l         <= '0;
      r_acc       <= '0;
      r_ovf_acc   <= 1'b0;
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_ovf       <= 1'b0;
    end else if (w_adv) begin
      r_p[0] <= w_pext;
      r_v[0] <= in_valid;
      r_f[0] <= first;
      r_l[0] <= last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        r_p[i] <= r_p[i-1];
        r_v[i] <= r_v[i-1];
        r_f[i] <= r_f[i-1];
        r_l[i] <= r_l[i-1];
      end
      if (r_v[L]) begin
        r_acc     <= w_acc_n;
        r_ovf_acc <= w_ovf_n;
      end
      // Advancing with out_valid set implies out_ready, so the old result is consumed here.
      r_out_valid <= r_v[L] & r_l[L];
      if (r_v[L] & r_l[L]) begin
        r_dout <= w_acc_n;
        r_ovf  <= w_ovf_n;
      end
    end
  end
endmodule

// File: tb/tb_myproject_mac_pipe.sv
// tb_myproject_mac_pipe: directed and randomized checks of three MAC configurations against an arithmetic model
module tb_myproject_mac_pipe;
  logic clk = 1'b0;
  logic rst_n, ce, in_valid, first, last, out_ready;
  logic signed [15:0] din0;
  logic signed [5:0]  din1;
  logic ir_a, ir_s, ir_w, ov_a, ov_s, ov_w, of_a, of_s, of_w;
  logic signed [31:0] d_a;
  logic signed [23:0] d_s, d_w;
  int n_cmp = 0, n_err = 0;
  bit rnd = 0;

  always #5 clk = ~clk;

  myproject_mac_pipe u_a (.ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_ready(ir_a),
    .din0(din0), .din1(din1), .first(first), .last(last), .out_valid(ov_a), .out_ready(out_ready),
    .dout(d_a), .ovf(of_a));
  myproject_mac_pipe #(.acc_WIDTH(24), .SATURATE(1)) u_s (.ap_clk(clk), .ap_rst_n(rst_n), .ce(ce),
    .in_valid(in_valid), .in_ready(ir_s), .din0(din0), .din1(din1), .first(first), .last(last),
    .out_valid(ov_s), .out_ready(out_ready), .dout(d_s), .ovf(of_s));
  myproject_mac_pipe #(.acc_WIDTH(24), .SATURATE(0)) u_w (.ap_clk(clk), .ap_rst_n(rst_n), .ce(ce),
    .in_valid(in_valid), .in_ready(ir_w), .din0(din0), .din1(din1), .first(first), .last(last),
    .out_valid(ov_w), .out_ready(out_ready), .dout(d_w), .ovf(of_w));

  typedef struct packed {
    logic signed [63:0] d0, d1, d2;
    logic o0, o1, o2;
  } res_t;
  res_t q[$];
  longint m_acc[3];
  bit m_ov[3];
  int m_w[3] = '{32, 24, 24};
  bit m_sat[3] = '{0, 1, 0};

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 0;
      m_ov[k] = 0;
    end
    q.delete();
  endtask

  task automatic model_beat(input int a, input int b, input bit f, input bit l);
    longint p, s, mx, mn;
    bit o;
    res_t r;
    p = longint'(a) * longint'(b);
    for (int k = 0; k < 3; k++) begin
      mx = (longint'(1) <<< (m_w[k] - 1)) - 1;
      mn = -(longint'(1) <<< (m_w[k] - 1));
      s = (f ? 0 : m_acc[k]) + p;
      o = (s > mx) || (s < mn);
      if (o) s = m_sat[k] ? (s > mx ? mx : mn) : (s > mx ? s - (longint'(1) <<< m_w[k]) : s + (longint'(1) <<< m_w[k]));
      m_acc[k] = s;
      m_ov[k] = (f ? 1'b0 : m_ov[k]) | o;
    end
    if (l) begin
      r.d0 = m_acc[0]; r.d1 = m_acc[1]; r.d2 = m_acc[2];
      r.o0 = m_ov[0];  r.o1 = m_ov[1];  r.o2 = m_ov[2];
      q.push_back(r);
    end
  endtask

  task automatic beat(input int a, input int b, input bit f, input bit l);
    bit acc, done;
    done = 0;
    in_valid = 1'b1;
    din0 = 16'(a);
    din1 = 6'(b);
    first = f;
    last = l;
    for (int c = 0; c < 200 && !done; c++) begin
      if (rnd) begin
        ce = $urandom_range(0, 7) != 0;
        out_ready = $urandom_range(0, 3) != 0;
      end
      @(negedge clk);
      acc = ir_a;
      @(posedge clk);
      #1;
      done = acc;
    end
    in_valid = 1'b0;
    if (done) model_beat(a, b, f, l);
    else chk("beat_accept_timeout", 0, 1);
  endtask

  task automatic drain();
    ce = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && q.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  always @(negedge clk) begin
    res_t e;
    if (rst_n && ce && out_ready && ov_a) begin
      n_cmp++;
      assert (q.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_result observed=%0d expected=none", d_a);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("dout_acc32", d_a, e.d0);
        chk("ovf_acc32", of_a, e.o0);
        chk("valid_sat24", ov_s, 1);
        chk("dout_sat24", d_s, e.d1);
        chk("ovf_sat24", of_s, e.o1);
        chk("valid_wrap24", ov_w, 1);
        chk("dout_wrap24", d_w, e.d2);
        chk("ovf_wrap24", of_w, e.o2);
      end
    end
  end

  initial begin
    logic [15:0] ra;
    logic [5:0] rb;
    int nb;
    bit fr;
    rst_n = 1'b0; ce = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    din0 = '0; din1 = '0; first = 1'b0; last = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {ov_a, ov_s, ov_w}, 0);
    chk("rst_dout", d_a, 0);
    chk("rst_ovf", {of_a, of_s, of_w}, 0);
    chk("rst_in_ready", ir_a, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // basic frame and result latency
    beat(100, 3, 1, 0); beat(-200, 5, 0, 0); beat(7, -32, 0, 0); beat(1000, 31, 0, 1);
    chk("lat_t1", ov_a, 0);
    @(posedge clk); #1;
    chk("lat_t2", ov_a, 0);
    @(posedge clk); #1;
    chk("lat_t3", ov_a, 1);
    chk("basic_dout", d_a, 30076);
    chk("basic_ovf", of_a, 0);
    drain();
    // single-beat extremes
    beat(-32768, -32, 1, 1); beat(-32768, 31, 1, 1);
    drain();
    // saturation / wrap frame then a fresh frame
    for (int i = 0; i < 9; i++) beat(32767, 31, i == 0, i == 8);
    beat(1, 1, 1, 1);
    drain();
    // backpressure: two single-beat frames held behind out_ready=0
    out_ready = 1'b0;
    beat(11, 3, 1, 1); beat(-5, 7, 1, 1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_in_ready", ir_a, 0);
      chk("bp_held_valid", ov_a, 1);
      chk("bp_held_dout", d_a, 33);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_second_valid", ov_a, 1);
    chk("bp_second_dout", d_a, -35);
    drain();
    // clock enable freeze mid-frame
    beat(3, 4, 1, 0); beat(5, 6, 0, 0);
    ce = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("ce_in_ready", ir_a, 0);
      chk("ce_out_valid", ov_a, 0);
    end
    ce = 1'b1;
    beat(7, 8, 0, 1);
    drain();
    // reset mid-frame drops the frame
    beat(9, 9, 1, 0); beat(2, 2, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {ov_a, ov_s, ov_w}, 0);
    chk("midrst_dout", {d_a, d_s, d_w}, 0);
    chk("midrst_ovf", {of_a, of_s, of_w}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    beat(2, 3, 0, 1);
    beat(4, 5, 1, 1);
    drain();
    // randomized frames with backpressure, ce gaps and bubbles
    rnd = 1;
    for (int f = 0; f < 60; f++) begin
      nb = $urandom_range(1, 8);
      fr = $urandom_range(0, 7) != 0;
      for (int i = 0; i < nb; i++) begin
        ra = 16'($urandom);
        rb = 6'($urandom);
        beat(int'($signed(ra)), int'($signed(rb)), fr && i == 0, i == nb - 1);
        if ($urandom_range(0, 4) == 0) begin
          @(posedge clk); #1;
        end
      end
    end
    rnd = 0;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
